// File: rtl/fifoout_rd_sched.sv
// Read-side scheduler for the 256-to-32 output prefetch FIFO.
// Pops words in frame/line order onto a registered valid/ready stream.
module fifoout_rd_sched #(
  parameter int DATA_W   = 32,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int H_GAP    = 16,
  parameter int H_W      = 11,
  parameter int V_W      = 10
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              frame_start,
  output logic              busy,
  output logic              line_req,
  output logic [V_W-1:0]    line_req_idx,
  output logic              fifo_rd_en,
  input  logic              fifo_rd_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [15:0]       underflow_cnt
);

  localparam int G_W = $clog2(H_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_LINE,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic [G_W-1:0] gap;
  logic           load;
  logic           last_h;
  logic           last_v;
  logic           gap_done;
  logic           starve;

  assign load     = (state == S_LINE) & fifo_rd_vld
                  & (~out_valid | out_ready);
  assign last_h   = h == H_W'(H_ACTIVE - 1);
  assign last_v   = v == V_W'(V_ACTIVE - 1);
  assign gap_done = gap == G_W'(H_GAP - 1);
  assign starve   = (state == S_LINE) & ~fifo_rd_vld
                  & (~out_valid | out_ready);
  assign fifo_rd_en = load;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (frame_start) state_nxt = S_PREFILL;
      S_PREFILL: if (fifo_rd_vld) state_nxt = S_LINE;
      S_LINE: begin
        if (load & last_h)
          state_nxt = last_v ? S_DRAIN : S_GAP;
      end
      S_GAP:     if (gap_done) state_nxt = S_LINE;
      S_DRAIN:   if (!out_valid) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Refill request runs one line ahead of the line being popped.
  always_comb begin
    line_req     = 1'b0;
    line_req_idx = '0;
    unique case (1'b1)
      (state == S_IDLE): line_req = frame_start;
      (state == S_LINE): begin
        line_req     = load & (h == '0) & ~last_v;
        line_req_idx = v + V_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      busy          <= 1'b0;
      h             <= '0;
      v             <= '0;
      gap           <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_sof       <= 1'b0;
      out_eol       <= 1'b0;
      out_eof       <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if ((state == S_IDLE) & frame_start) begin
        busy <= 1'b1;
        h    <= '0;
        v    <= '0;
      end
      if ((state == S_DRAIN) & ~out_valid)
        busy <= 1'b0;
      if (state == S_GAP)
        gap <= gap + G_W'(1);
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= fifo_rd_data;
        out_sof   <= (h == '0) & (v == '0);
        out_eol   <= last_h;
        out_eof   <= last_h & last_v;
        if (last_h) begin
          h   <= '0;
          gap <= '0;
          if (!last_v) v <= v + V_W'(1);
        end else begin
          h <= h + H_W'(1);
        end
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
      if (starve & (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifoout_rd_sched.sv
// Bench for fifoout_rd_sched: 4x3 frames, gap 2, random and directed
// FIFO/downstream behaviour against an index-based stream model.
module tb_fifoout_rd_sched;

  localparam int HA = 4;
  localparam int VA = 3;
  localparam int FW = HA * VA;

  logic        clk = 1'b0;
  logic        rd_rst;
  logic        frame_start;
  logic        busy;
  logic        line_req;
  logic [1:0]  line_req_idx;
  logic        fifo_rd_en;
  logic        fifo_rd_vld;
  logic [31:0] fifo_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic [15:0] underflow_cnt;

  fifoout_rd_sched #(
    .DATA_W(32), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_GAP(2), .H_W(3), .V_W(2)
  ) dut (
    .rd_clk(clk),
    .rd_rst(rd_rst),
    .frame_start(frame_start),
    .busy(busy),
    .line_req(line_req),
    .line_req_idx(line_req_idx),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sof(out_sof),
    .out_eol(out_eol),
    .out_eof(out_eof),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          p        = 0;
  int          n        = 0;
  int          req_cnt  = 0;
  int          rdy_mode = 0;
  int          vld_mode = 0;
  int          t0       = 0;
  int          hs_t [16];
  bit          fs_req   = 1'b0;
  bit          eof_hs   = 1'b0;
  bit          in_frame = 1'b0;
  logic [31:0] src [1024];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after negedge; everything is sampled 1 time unit
  // later, i.e. the values the next posedge will act on.
  task automatic tick();
    @(negedge clk);
    cyc++;
    eof_hs = 1'b0;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    case (vld_mode)
      0:       fifo_rd_vld = 1'b1;
      1:       fifo_rd_vld = 1'b0;
      default: fifo_rd_vld = ($urandom_range(0, 3) != 0);
    endcase
    frame_start  = fs_req;
    fs_req       = 1'b0;
    fifo_rd_data = src[p % 1024];
    #1;
    if (fifo_rd_en) begin
      chk("rd_en_legal",
          32'(fifo_rd_vld & (~out_valid | out_ready)), 1);
      p++;
    end
    if (out_valid) begin
      chk("data", out_data, src[n % 1024]);
      chk("sof", 32'(out_sof), 32'(n % FW == 0));
      chk("eol", 32'(out_eol), 32'(n % HA == HA - 1));
      chk("eof", 32'(out_eof), 32'(n % FW == FW - 1));
      if (out_ready) begin
        if (n < 16) hs_t[n] = cyc;
        if (out_eof) begin
          eof_hs   = 1'b1;
          in_frame = 1'b0;
        end
        n++;
      end
    end
    if (line_req) begin
      chk("req_idx", 32'(line_req_idx), req_cnt % VA);
      if (req_cnt % VA == 0) in_frame = 1'b1;
      req_cnt++;
    end
  endtask

  task automatic start_frame(input string tag);
    fs_req = 1'b1;
    tick();
    t0 = cyc;
    chk({tag, "_start_busy0"}, 32'(busy), 0);
    chk({tag, "_start_req"}, 32'(line_req), 1);
    tick();
    chk({tag, "_busy_on"}, 32'(busy), 1);
  endtask

  task automatic wait_n(input int target, input string tag);
    int k = 0;
    while (n < target && k < 500) begin
      tick();
      k++;
    end
    chk({tag, "_wait_words"}, 32'(n >= target), 1);
  endtask

  task automatic wait_eof(input string tag);
    int k = 0;
    while (!eof_hs && k < 500) begin
      tick();
      k++;
    end
    chk({tag, "_wait_eof"}, 32'(eof_hs), 1);
  endtask

  task automatic wait_idle(input string tag, input bit pulse);
    int k = 0;
    tick();
    while (busy !== 1'b0 && k < 500) begin
      if (pulse && in_frame) fs_req = 1'b1;
      tick();
      k++;
    end
    chk({tag, "_wait_idle"}, 32'(busy), 0);
    chk({tag, "_frame_whole"}, 32'(n % FW), 0);
    chk({tag, "_req_count"}, 32'(req_cnt), 32'(VA * (n / FW)));
    chk({tag, "_out_empty"}, 32'(out_valid), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_line_req"}, 32'(line_req), 0);
    chk({tag, "_req_idx"}, 32'(line_req_idx), 0);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_sof"}, 32'(out_sof), 0);
    chk({tag, "_eol"}, 32'(out_eol), 0);
    chk({tag, "_eof"}, 32'(out_eof), 0);
    chk({tag, "_uflow"}, 32'(underflow_cnt), 0);
  endtask

  task automatic model_reset();
    p        = 0;
    n        = 0;
    req_cnt  = 0;
    in_frame = 1'b0;
  endtask

  initial begin
    int n0;
    rd_rst       = 1'b1;
    frame_start  = 1'b0;
    fifo_rd_vld  = 1'b0;
    fifo_rd_data = '0;
    out_ready    = 1'b0;
    foreach (src[i]) src[i] = $urandom;

    // Power-on reset
    vld_mode = 1;
    tick();
    tick();
    rd_rst = 1'b0;
    model_reset();
    tick();
    check_reset_vals("por");

    // Full-rate frame: timing of first word, gaps and busy fall
    vld_mode = 0;
    rdy_mode = 0;
    start_frame("t1");
    wait_eof("t1");
    chk("t1_first_lat", 32'(hs_t[0] - t0), 3);
    chk("t1_in_line", 32'(hs_t[1] - hs_t[0]), 1);
    chk("t1_gap0", 32'(hs_t[4] - hs_t[3]), 3);
    chk("t1_gap1", 32'(hs_t[8] - hs_t[7]), 3);
    chk("t1_line2", 32'(hs_t[11] - hs_t[8]), 3);
    chk("t1_words", 32'(n), 12);
    tick();
    chk("t1_busy_hold", 32'(busy), 1);
    tick();
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_req_count", 32'(req_cnt), 3);
    chk("t1_uflow", 32'(underflow_cnt), 0);

    // Downstream ready toggling every cycle
    rdy_mode = 1;
    start_frame("t2");
    wait_idle("t2", 1'b0);
    chk("t2_uflow", 32'(underflow_cnt), 0);

    // FIFO starves for 5 cycles in the middle of line 1
    rdy_mode = 0;
    n0 = n;
    start_frame("t3");
    wait_n(n0 + 6, "t3");
    vld_mode = 1;
    repeat (5) tick();
    vld_mode = 0;
    wait_idle("t3", 1'b0);
    chk("t3_uflow", 32'(underflow_cnt), 5);

    // Pulse on the DRAIN exit is ignored, the next cycle's is taken
    start_frame("t4a");
    wait_eof("t4a");
    fs_req = 1'b1;
    tick();
    chk("t4_drain_req", 32'(line_req), 0);
    chk("t4_drain_busy", 32'(busy), 1);
    start_frame("t4b");
    wait_idle("t4b", 1'b1);

    // Reset in the middle of line 1
    n0 = n;
    start_frame("t5");
    wait_n(n0 + 6, "t5");
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    model_reset();
    tick();
    check_reset_vals("t5_rst");
    start_frame("t5r");
    wait_idle("t5r", 1'b0);
    chk("t5_words", 32'(n), 12);

    // Random FIFO/ready with stray frame_start pulses
    vld_mode = 2;
    rdy_mode = 2;
    n0 = n;
    start_frame("t6");
    for (int k = 0; k < 5000 && n < n0 + 6 * FW; k++) begin
      if ($urandom_range(0, 7) == 0) fs_req = 1'b1;
      tick();
    end
    chk("t6_words", 32'(n >= n0 + 6 * FW), 1);
    wait_idle("t6", 1'b0);

    // Saturation of the starvation counter
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    model_reset();
    vld_mode = 1;
    rdy_mode = 0;
    fs_req   = 1'b1;
    tick();
    vld_mode = 0;
    tick();
    vld_mode = 1;
    repeat (65535) tick();
    chk("t7_uflow_fffe", 32'(underflow_cnt), 32'h0000FFFE);
    tick();
    chk("t7_uflow_ffff", 32'(underflow_cnt), 32'h0000FFFF);
    repeat (5) tick();
    chk("t7_uflow_sat", 32'(underflow_cnt), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifoout_rd_sched.md
Name: fifoout_rd_sched

Overview:
Read-side scheduler for the 256-to-32 output prefetch FIFO. It pops 32-bit words from the FIFO read port in frame/line order and presents them downstream on a registered valid/ready stream with sof/eol/eof markers. It inserts fixed inter-line gaps and issues one-line-ahead refill requests to the write-side fetch logic. It also counts underflow (starvation) cycles.

Parameters:
DATA_W, 32, FIFO read and output data width
H_ACTIVE, 1280, words per line (>=2)
V_ACTIVE, 720, lines per frame (>=2)
H_GAP, 16, idle cycles between lines (>=1)
H_W, 11, h counter width (>= clog2(H_ACTIVE))
V_W, 10, v counter width (>= clog2(V_ACTIVE))

Ports:
rd_clk  in  1  clock
rd_rst  in  1  synchronous reset, active-high
frame_start  in  1  one-cycle pulse; starts a frame when idle
busy  out  1  high while a frame is in progress
line_req  out  1  one-cycle refill request for line line_req_idx
line_req_idx  out  V_W  line index being requested
fifo_rd_en  out  1  FIFO pop
fifo_rd_vld  in  1  FIFO head word valid
fifo_rd_data  in  DATA_W  FIFO head word
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  output word
out_sof  out  1  first word of frame (qualified by out_valid)
out_eol  out  1  last word of line
out_eof  out  1  last word of frame
underflow_cnt  out  16  saturating starvation-cycle count

Behaviour:
- Reset: state IDLE. busy, line_req, out_valid, out_sof, out_eol and out_eof are 0. line_req_idx, h/v counters, out_data and underflow_cnt are 0. Reset mid-frame abandons the frame; the FIFO is not flushed by this block.
- States: IDLE, PREFILL, LINE, GAP, DRAIN.
- IDLE: on frame_start go to PREFILL. The same cycle the pulse is seen, assert line_req with line_req_idx=0. v=0, h=0, busy=1 from the next cycle.
- PREFILL: wait for fifo_rd_vld=1, then go to LINE. No underflow counting here.
- Output register: load = (state==LINE) & fifo_rd_vld & (!out_valid | out_ready). fifo_rd_en = load; fifo_rd_en is combinational. On load, out_data<=fifo_rd_data and markers are computed from the pre-increment h/v. If out_valid & out_ready & !load, then out_valid<=0. Output lags the FIFO head by 1 cycle.
- Markers on loaded word:
  - sof = (h==0 & v==0)
  - eol = (h==H_ACTIVE-1)
  - eof = eol & (v==V_ACTIVE-1)
- LINE:
  - Each load increments h.
  - Load with h==0 and v<V_ACTIVE-1: pulse line_req with line_req_idx=v+1 (one-line-ahead refill).
  - Load with h==H_ACTIVE-1: h<=0. If v==V_ACTIVE-1, go to DRAIN; else v<=v+1, gap counter<=0, go to GAP.
- GAP: count H_GAP cycles, then go to LINE. No pops in GAP. The output register may still drain.
- DRAIN: wait until out_valid==0 (last word accepted), then go to IDLE and set busy<=0 in the same transition.
- Underflow: in LINE, if (!out_valid | out_ready) & !fifo_rd_vld, increment underflow_cnt, saturating at 16'hFFFF. Cleared only by reset.
- frame_start outside IDLE is ignored; it has no effect on the running frame.
- out_ready low holds out_valid, out_data and the markers stable (standard valid/ready; no combinational path from out_ready to out_valid).
- Back-to-back: frame_start in the same cycle DRAIN exits is ignored (the FSM is not yet IDLE); one cycle later it is accepted.

Test Plan:
- Params H_ACTIVE=4, V_ACTIVE=3, H_GAP=2; FIFO always valid, out_ready=1; pulse frame_start -> 12 words out in order. sof on word 0; eol on words 3, 7, 11; eof on word 11 only. 2 idle cycles between lines. line_req pulses with idx 0, 1, 2. busy falls 1 cycle after the eof handshake. underflow_cnt=0.
- Same params, out_ready toggling 1/0 every cycle -> no word lost or duplicated. out_data is stable while out_ready=0. fifo_rd_en asserts only when the register is empty or being accepted.
- fifo_rd_vld forced low for 5 cycles mid-line 1, out_ready=1 -> underflow_cnt=5. Stream resumes with the correct h position and markers.
- frame_start pulses during LINE and GAP -> ignored. Exactly 12 words and one eof. A pulse 1 cycle after busy falls starts a new frame with sof.
- rd_rst asserted mid-line 1 -> next cycle all outputs at reset values and state IDLE. A new frame_start restarts at line_req_idx=0 with sof.
- underflow_cnt preload scenario (starve 65540 cycles) -> saturates at 16'hFFFF.
